// File: rtl/multiport_regfile_pkg.sv
// rtl/multiport_regfile_pkg.sv - shared register-file widths, types and address helper
package regfile_pkg;
   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;

   typedef logic [DATA_WIDTH-1:0]     reg_data_t;
   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

   function automatic logic addr_valid(int unsigned addr, int unsigned num_regs);
      return addr < num_regs;
   endfunction
endpackage

// File: rtl/multiport_regfile_if.sv
// rtl/multiport_regfile_if.sv - read, writeback and issue bundle of the multiport register file
interface multiport_regfile_if #(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int NUM_REGS   = 32,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2
);
   localparam int AW = $clog2(NUM_REGS);

   logic [NUM_RD-1:0][AW-1:0]         rd_addr;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]                 rd_busy;
   logic [NUM_WR-1:0]                 wr_en;
   logic [NUM_WR-1:0][AW-1:0]         wr_addr;
   logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data;
   logic                              issue_en;
   logic [AW-1:0]                     issue_addr;
   logic [NUM_REGS-1:0]               pending;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
      input  rd_data, rd_busy, pending
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
      output rd_data, rd_busy, pending
   );
endinterface

// File: rtl/multiport_regfile_scoreboard.sv
// rtl/multiport_regfile_scoreboard.sv - pending-write scoreboard and per-read-port busy flags
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_WR-1:0]         wr_en,
   input  logic [NUM_WR-1:0][AW-1:0] wr_addr,
   input  logic                      issue_en,
   input  logic [AW-1:0]             issue_addr,
   input  logic [NUM_RD-1:0][AW-1:0] rd_addr,
   output logic [NUM_RD-1:0]         rd_busy,
   output logic [NUM_REGS-1:0]       pending
);
   logic [NUM_RD-1:0] hit;

   function automatic logic tracked(logic [AW-1:0] addr);
      return addr_valid(32'(addr), NUM_REGS) && !(ZERO_REG && addr == '0);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j] && tracked(wr_addr[j]))
               pending[wr_addr[j]] <= 1'b0;
         // applied last so a newly issued producer supersedes a same-cycle writeback
         if (issue_en && tracked(issue_addr))
            pending[issue_addr] <= 1'b1;
      end
   end

   always_comb begin
      rd_busy = '0;
      hit     = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         for (int j = 0; j < NUM_WR; j++)
            if (wr_en[j] && wr_addr[j] == rd_addr[i])
               hit[i] = 1'b1;
         if (tracked(rd_addr[i]))
            rd_busy[i] = pending[rd_addr[i]] && !(BYPASS && hit[i]);
      end
   end
endmodule

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - N-read/M-write register file with bypass, zero register and scoreboard
module multiport_regfile
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int NUM_REGS   = 32,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 2,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS     = 1'b1
) (
   input logic                clk,
   input logic                reset,
   multiport_regfile_if.slave bus
);
   localparam int AW = $clog2(NUM_REGS);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   function automatic logic storable(logic [AW-1:0] addr);
      return addr_valid(32'(addr), NUM_REGS) && !(ZERO_REG && addr == '0);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NUM_REGS; r++)
            regs[r] <= '0;
      end else begin
         // later ports overwrite earlier ones, so the highest index wins a conflict
         for (int j = 0; j < NUM_WR; j++)
            if (bus.wr_en[j] && storable(bus.wr_addr[j]))
               regs[bus.wr_addr[j]] <= bus.wr_data[j];
      end
   end

   always_comb begin
      bus.rd_data = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         if (storable(bus.rd_addr[i])) begin
            bus.rd_data[i] = regs[bus.rd_addr[i]];
            // forwarding is suppressed during reset so reads track the cleared array
            if (BYPASS && reset)
               for (int j = 0; j < NUM_WR; j++)
                  if (bus.wr_en[j] && bus.wr_addr[j] == bus.rd_addr[i])
                     bus.rd_data[i] = bus.wr_data[j];
         end
      end
   end

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (bus.wr_en),
      .wr_addr    (bus.wr_addr),
      .issue_en   (bus.issue_en),
      .issue_addr (bus.issue_addr),
      .rd_addr    (bus.rd_addr),
      .rd_busy    (bus.rd_busy),
      .pending    (bus.pending)
   );
endmodule
